systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: SystolicArray

Interface
- REQ-001 Parameter QUEUE_SIZE, default 8: number of storage cells (maximum element count), >= 2.
- REQ-002 Parameter DATA_WIDTH, default 16: element width, unsigned priority value.
- REQ-003 i_CLK  input  1: single clock, all state rising-edge triggered.
- REQ-004 i_RST  input  1: asynchronous, active-high reset.
- REQ-005 i_wrt  input  1: write request; qualifies i_data.
- REQ-006 i_read  input  1: read request; removes the root element.
- REQ-007 i_data  input  DATA_WIDTH: value to insert.
- REQ-008 o_full  output  1: high when element count == QUEUE_SIZE.
- REQ-009 o_empty  output  1: high when element count == 0.
- REQ-010 o_data  output  DATA_WIDTH: current maximum (root) element; 0 when empty.

Function
- REQ-011 Max-priority queue built as a linear systolic array of QUEUE_SIZE cells, each holding {valid, data}; cell 0 is the root; o_data = cell 0 data.
- REQ-012 Sorted invariant: for every valid cell i>0, data[i-1] >= data[i]; valid cells are contiguous from cell 0; each cell compares/exchanges only with its immediate neighbours.
- REQ-013 Operation decode per cycle: i_wrt&!i_read = ENQUEUE; !i_wrt&i_read = DEQUEUE; i_wrt&i_read = REPLACE; neither = idle.
- REQ-014 ENQUEUE (not full): new value enters at cell 0; at each cell the larger of resident and incoming stays, the smaller ripples one cell right per cycle; count +1.
- REQ-015 DEQUEUE (not empty): cell 0 element discarded; each cell pulls the larger element from its right neighbour, one cell per cycle; last valid cell becomes invalid; count -1.
- REQ-016 REPLACE (not empty): root discarded and i_data inserted in same operation; count unchanged; legal when full.
- REQ-017 REPLACE when empty SHALL behave as ENQUEUE.
- REQ-018 ENQUEUE when o_full SHALL be ignored (no state change).
- REQ-019 DEQUEUE when o_empty SHALL be ignored; o_data stays 0.
- REQ-020 Latency: o_data, o_full, o_empty SHALL reflect the completed operation on the first rising edge after the accepting edge (valid one cycle after), independent of ripple still in progress deeper in the array.
- REQ-021 Throughput: one operation accepted every 2 cycles; a request in the cycle immediately following an accepted operation SHALL be ignored.
- REQ-022 Ripple from an operation SHALL never be overtaken by a later operation; the invariant is fully restored within QUEUE_SIZE cycles of the last operation.
- REQ-023 Equal values are legal; duplicates are both retained, order among equals unspecified.
- REQ-024 o_full and o_empty derive from a count register (0..QUEUE_SIZE, width clog2(QUEUE_SIZE+1)) or the cell valid bits; never both high.

Reset
- REQ-025 While i_RST is high, all cells invalid, data 0, count 0 immediately (asynchronous).
- REQ-026 Reset outputs: o_data=0, o_empty=1, o_full=0.
- REQ-027 Reset asserted mid-operation SHALL abort any ripple in progress; first operation accepted on the first edge after deassertion.

Verification (QUEUE_SIZE=8, DATA_WIDTH=16, ops spaced >=3 cycles)
- REQ-028 Reset -> o_empty=1, o_full=0, o_data=0; DEQUEUE on empty -> unchanged.
- REQ-029 ENQUEUE 5,900,17,300,1024,0,77,300 -> o_data after each: 5,900,900,900,1024,1024,1024,1024; after 8th o_full=1; ENQUEUE 999 ignored, o_data=1024.
- REQ-030 Then 8 DEQUEUEs -> o_data sequence 900,300,300,77,17,5,0 then 0 with o_empty=1; o_full=0 after first.
- REQ-031 Enqueue 10,20,30 then REPLACE 25 -> o_data 25; REPLACE 5 -> o_data 20; count stays 3; REPLACE on empty queue with 42 -> o_data 42, o_empty=0.
- REQ-032 Back-to-back: ENQUEUE 50 then ENQUEUE 60 in next cycle -> second ignored, o_data 50.
- REQ-033 100 random ENQUEUE/DEQUEUE/REPLACE ops with values 0..1024 -> o_data always equals max of a reference model, 0 when empty; flags match model count.

Source files
------------

// File: rtl/systolic_array_if.sv
// Request/status bundle for the systolic priority queue.
// The slave side is the queue; the master side issues write/read requests.
interface systolic_array_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  i_wrt;
  logic                  i_read;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_full;
  logic                  o_empty;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (output i_wrt, i_read, i_data, input o_full, o_empty, o_data);
  modport slave  (input i_wrt, i_read, i_data, output o_full, o_empty, o_data);
endinterface

// File: rtl/systolic_array.sv
// Max-priority queue as a linear systolic array; cell 0 holds the root.
// Operations launch a token at cell 0 that ripples right one cell per cycle.
module systolic_array #(
  parameter int unsigned QUEUE_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic              i_CLK,
  input logic              i_RST,
  systolic_array_if.slave  bus
);
  localparam int unsigned CW = $clog2(QUEUE_SIZE + 1);

  typedef enum logic [1:0] {TK_NONE, TK_INS, TK_DEL, TK_REP} tok_e;

  logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] data_q, data_d, nxt_data;
  logic [QUEUE_SIZE-1:0]                 valid_q, valid_d, nxt_valid;
  tok_e                                  tok_q [QUEUE_SIZE];
  tok_e                                  tok_d [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0]                 val_q [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0]                 val_d [QUEUE_SIZE];
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic                                  busy_q, busy_d;
  logic                                  full, empty;
  tok_e                                  tok0, cur_tok, carry_tok;
  logic [DATA_WIDTH-1:0]                 cur_val, carry_val;

  always_comb begin
    full   = (cnt_q == CW'(QUEUE_SIZE));
    empty  = (cnt_q == '0);
    tok0   = TK_NONE;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (bus.i_wrt && bus.i_read) begin
        if (empty) begin
          tok0  = TK_INS;
          cnt_d = cnt_q + CW'(1);
        end else begin
          tok0 = TK_REP;
        end
      end else if (bus.i_wrt) begin
        if (!full) begin
          tok0  = TK_INS;
          cnt_d = cnt_q + CW'(1);
        end
      end else if (bus.i_read) begin
        if (!empty) begin
          tok0  = TK_DEL;
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
    busy_d = (tok0 != TK_NONE);

    // Accepted ops are spaced two cycles apart, so tokens never sit in
    // adjacent cells and a right neighbour is always settled when read.
    nxt_data  = data_q >> DATA_WIDTH;
    nxt_valid = valid_q >> 1;
    data_d    = data_q;
    valid_d   = valid_q;
    cur_tok   = TK_NONE;
    cur_val   = '0;
    carry_tok = TK_NONE;
    carry_val = '0;
    for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
      cur_tok   = (i == 0) ? tok0 : tok_q[i];
      cur_val   = (i == 0) ? bus.i_data : val_q[i];
      tok_d[i]  = carry_tok;
      val_d[i]  = carry_val;
      carry_tok = TK_NONE;
      carry_val = '0;
      case (cur_tok)
        TK_INS: begin
          if (!valid_q[i]) begin
            data_d[i]  = cur_val;
            valid_d[i] = 1'b1;
          end else if (cur_val > data_q[i]) begin
            data_d[i] = cur_val;
            carry_tok = TK_INS;
            carry_val = data_q[i];
          end else begin
            carry_tok = TK_INS;
            carry_val = cur_val;
          end
        end
        TK_DEL: begin
          if (nxt_valid[i]) begin
            data_d[i] = nxt_data[i];
            carry_tok = TK_DEL;
          end else begin
            data_d[i]  = '0;
            valid_d[i] = 1'b0;
          end
        end
        TK_REP: begin
          if (nxt_valid[i] && (nxt_data[i] > cur_val)) begin
            data_d[i] = nxt_data[i];
            carry_tok = TK_REP;
            carry_val = cur_val;
          end else begin
            data_d[i] = cur_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
        tok_q[i] <= TK_NONE;
        val_q[i] <= '0;
      end
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int unsigned i = 0; i < QUEUE_SIZE; i++) begin
        tok_q[i] <= tok_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

  assign bus.o_data  = data_q[0];
  assign bus.o_full  = full;
  assign bus.o_empty = empty;
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: directed scenarios plus random
// operations compared against an unsorted-list priority queue model.
module tb_systolic_array;
  localparam int QS = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_array_if #(.DATA_WIDTH(DW)) bus ();

  systolic_array #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int model[$];

  function automatic int model_max();
    int m = 0;
    foreach (model[k]) if (model[k] > m) m = model[k];
    return m;
  endfunction

  function automatic void model_del_max();
    int idx = 0;
    foreach (model[k]) if (model[k] > model[idx]) idx = k;
    model.delete(idx);
  endfunction

  function automatic void model_op(bit w, bit r, int d);
    if (w && !r) begin
      if (model.size() < QS) model.push_back(d);
    end else if (!w && r) begin
      if (model.size() > 0) model_del_max();
    end else if (w && r) begin
      if (model.size() > 0) model_del_max();
      model.push_back(d);
    end
  endfunction

  // One request held for a single cycle, sampled after the following edge,
  // then an idle gap so consecutive accepts are three cycles apart.
  task automatic drive(bit w, bit r, int d);
    @(negedge clk);
    bus.i_wrt  = w;
    bus.i_read = r;
    bus.i_data = DW'(d);
    @(negedge clk);
    bus.i_wrt  = 1'b0;
    bus.i_read = 1'b0;
    @(posedge clk);
    #1;
    model_op(w, r, d);
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.i_wrt = 1'b0; bus.i_read = 1'b0; bus.i_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.o_empty); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
    checks++; if (bus.o_data !== 16'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", bus.o_data); end
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    drive(1'b0, 1'b1, 0);
    checks++; if (bus.o_empty !== 1'b1 || bus.o_data !== 16'd0) begin
      errors++; $display("FAIL deq_empty got empty=%b data=%0d exp empty=1 data=0", bus.o_empty, bus.o_data);
    end
  endtask

  task automatic test_enqueue();
    int vals[8] = '{5, 900, 17, 300, 1024, 0, 77, 300};
    int expv[8] = '{5, 900, 900, 900, 1024, 1024, 1024, 1024};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      checks++; if (bus.o_data !== 16'(expv[i])) begin
        errors++; $display("FAIL enq_data[%0d] got=%0d exp=%0d", i, bus.o_data, expv[i]);
      end
      checks++; if (bus.o_full !== (i == 7) || bus.o_empty !== 1'b0) begin
        errors++; $display("FAIL enq_flags[%0d] got full=%b empty=%b exp full=%b empty=0", i, bus.o_full, bus.o_empty, i == 7);
      end
    end
    drive(1'b1, 1'b0, 999);
    checks++; if (bus.o_data !== 16'd1024 || bus.o_full !== 1'b1) begin
      errors++; $display("FAIL enq_when_full got data=%0d full=%b exp data=1024 full=1", bus.o_data, bus.o_full);
    end
  endtask

  task automatic test_dequeue();
    int expv[8] = '{900, 300, 300, 77, 17, 5, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 0);
      checks++; if (bus.o_data !== 16'(expv[i])) begin
        errors++; $display("FAIL deq_data[%0d] got=%0d exp=%0d", i, bus.o_data, expv[i]);
      end
      checks++; if (bus.o_full !== 1'b0 || bus.o_empty !== (i == 7)) begin
        errors++; $display("FAIL deq_flags[%0d] got full=%b empty=%b exp full=0 empty=%b", i, bus.o_full, bus.o_empty, i == 7);
      end
    end
  endtask

  task automatic test_replace();
    int expv[3] = '{10, 5, 0};
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b0, 30);
    drive(1'b1, 1'b1, 25);
    checks++; if (bus.o_data !== 16'd25) begin errors++; $display("FAIL rep_25 got=%0d exp=25", bus.o_data); end
    drive(1'b1, 1'b1, 5);
    checks++; if (bus.o_data !== 16'd20) begin errors++; $display("FAIL rep_5 got=%0d exp=20", bus.o_data); end
    // Remaining contents {20,10,5}: three dequeues must drain exactly.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 0);
      checks++; if (bus.o_data !== 16'(expv[i]) || bus.o_empty !== (i == 2)) begin
        errors++; $display("FAIL rep_drain[%0d] got data=%0d empty=%b exp data=%0d empty=%b", i, bus.o_data, bus.o_empty, expv[i], i == 2);
      end
    end
    drive(1'b1, 1'b1, 42);
    checks++; if (bus.o_data !== 16'd42 || bus.o_empty !== 1'b0) begin
      errors++; $display("FAIL rep_on_empty got data=%0d empty=%b exp data=42 empty=0", bus.o_data, bus.o_empty);
    end
    drive(1'b0, 1'b1, 0);
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL rep_cleanup got empty=%b exp=1", bus.o_empty); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_wrt = 1'b1; bus.i_read = 1'b0; bus.i_data = 16'd50;
    @(negedge clk);
    bus.i_data = 16'd60;
    @(negedge clk);
    bus.i_wrt = 1'b0;
    @(posedge clk);
    #1;
    model_op(1'b1, 1'b0, 50);
    checks++; if (bus.o_data !== 16'd50) begin errors++; $display("FAIL b2b_data got=%0d exp=50", bus.o_data); end
    drive(1'b0, 1'b1, 0);
    checks++; if (bus.o_empty !== 1'b1 || bus.o_data !== 16'd0) begin
      errors++; $display("FAIL b2b_single got empty=%b data=%0d exp empty=1 data=0", bus.o_empty, bus.o_data);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 100 + 10 * i);
    @(negedge clk);
    bus.i_wrt = 1'b1; bus.i_data = 16'd3;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_data !== 16'd0) begin
      errors++; $display("FAIL async_reset got empty=%b full=%b data=%0d exp 1 0 0", bus.o_empty, bus.o_full, bus.o_data);
    end
    bus.i_wrt = 1'b0;
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.i_wrt = 1'b1; bus.i_data = 16'd7;
    @(negedge clk);
    bus.i_wrt = 1'b0;
    @(posedge clk);
    #1;
    model_op(1'b1, 1'b0, 7);
    checks++; if (bus.o_data !== 16'd7 || bus.o_empty !== 1'b0) begin
      errors++; $display("FAIL post_reset_op got data=%0d empty=%b exp data=7 empty=0", bus.o_data, bus.o_empty);
    end
    drive(1'b0, 1'b1, 0);
    checks++; if (bus.o_empty !== 1'b1 || bus.o_data !== 16'd0) begin
      errors++; $display("FAIL post_reset_drain got empty=%b data=%0d exp empty=1 data=0", bus.o_empty, bus.o_data);
    end
  endtask

  task automatic test_random();
    int sel, v, n;
    bit w, r;
    for (int i = 0; i < 100; i++) begin
      sel = int'($urandom_range(0, 9));
      v   = int'($urandom_range(0, 1024));
      w   = (sel < 4) || (sel >= 7);
      r   = (sel >= 4);
      drive(w, r, v);
      checks++; if (bus.o_data !== 16'(model_max()) || bus.o_full !== (model.size() == QS) ||
                    bus.o_empty !== (model.size() == 0)) begin
        errors++;
        $display("FAIL rand[%0d] got data=%0d full=%b empty=%b exp data=%0d full=%b empty=%b",
                 i, bus.o_data, bus.o_full, bus.o_empty, model_max(), model.size() == QS, model.size() == 0);
      end
    end
    n = model.size();
    for (int i = 0; i <= n; i++) begin
      drive(1'b0, 1'b1, 0);
      checks++; if (bus.o_data !== 16'(model_max()) || bus.o_empty !== (model.size() == 0)) begin
        errors++;
        $display("FAIL drain[%0d] got data=%0d empty=%b exp data=%0d empty=%b",
                 i, bus.o_data, bus.o_empty, model_max(), model.size() == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_dequeue();
    test_replace();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
